// File: rtl/backprop_stream_tx.sv
// Transmit-side sequencer for the backprop stack: buffers per-layer start/to-all/dense matrices,
// streams them layer by layer, then drains dc_dw through copy/reset and row-select sweeps.
module backprop_stream_tx #(
    parameter int unsigned DATA_SIZE      = 4,
    parameter int unsigned SIZE           = 3,
    parameter int unsigned MAX_LAYER_SIZE = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [1:0]                  wr_sel,
    input  logic [7:0]                  wr_layer,
    input  logic [7:0]                  wr_row,
    input  logic [DATA_SIZE*SIZE-1:0]   wr_data,
    input  logic                        start,
    input  logic [7:0]                  num_layers,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_SIZE*SIZE-1:0]   backprop_start,
    output logic [DATA_SIZE*SIZE-1:0]   backprop_to_all,
    output logic [DATA_SIZE*SIZE-1:0]   backprop_dense,
    output logic [32:0]                 current_layer_index,
    output logic [32:0]                 dc_dw_layer_index,
    output logic                        copy,
    output logic                        cal_dy_dy_old,
    output logic                        stack_reset
);

    localparam int unsigned ROW_W = DATA_SIZE * SIZE;
    localparam int unsigned LW    = (MAX_LAYER_SIZE > 1) ? $clog2(MAX_LAYER_SIZE) : 1;
    localparam int unsigned RW    = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [2:0] {StIdle, StStream, StCal, StCopy, StRead, StDone} state_e;

    logic [ROW_W-1:0] mem_start  [MAX_LAYER_SIZE][SIZE];
    logic [ROW_W-1:0] mem_to_all [MAX_LAYER_SIZE][SIZE];
    logic [ROW_W-1:0] mem_dense  [MAX_LAYER_SIZE][SIZE];

    state_e            state_q, state_d;
    logic [LW-1:0]     l_q, l_d, k_q, k_d;
    logic [RW-1:0]     r_q, r_d, j_q, j_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        n_clamp;
    logic              wr_ok;

    logic              busy_q, busy_d, done_q, done_d, cal_q, cal_d, copy_q, copy_d;
    logic              stream_d;
    logic [32:0]       cur_q, cur_d, dcdw_q, dcdw_d;
    logic [ROW_W-1:0]  bs_q, bs_d, ba_q, ba_d, bd_q, bd_d;

    assign n_clamp = (32'(num_layers) > MAX_LAYER_SIZE) ? 8'(MAX_LAYER_SIZE) : num_layers;

    // Writes are only honoured while idle so a running stream never sees a torn matrix.
    assign wr_ok = wr_en && !busy_q && (wr_sel != 2'd3) &&
                   (32'(wr_layer) < MAX_LAYER_SIZE) && (32'(wr_row) < SIZE);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            case (wr_sel)
                2'd0:    mem_start[wr_layer[LW-1:0]][wr_row[RW-1:0]]  <= wr_data;
                2'd1:    mem_to_all[wr_layer[LW-1:0]][wr_row[RW-1:0]] <= wr_data;
                2'd2:    mem_dense[wr_layer[LW-1:0]][wr_row[RW-1:0]]  <= wr_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        k_d     = k_q;
        r_d     = r_q;
        j_d     = j_q;
        n_d     = n_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    n_d     = n_clamp;
                    l_d     = '0;
                    r_d     = '0;
                    state_d = (n_clamp == 8'd0) ? StDone : StStream;
                end
            end
            StStream: begin
                if (32'(r_q) == SIZE - 1) state_d = StCal;
                else                      r_d     = r_q + RW'(1);
            end
            StCal: begin
                if (32'(l_q) + 32'd1 < 32'(n_q)) begin
                    l_d     = l_q + LW'(1);
                    r_d     = '0;
                    state_d = StStream;
                end else begin
                    k_d     = '0;
                    state_d = StCopy;
                end
            end
            StCopy: begin
                j_d     = '0;
                state_d = StRead;
            end
            StRead: begin
                if (32'(j_q) == SIZE - 1) begin
                    if (32'(k_q) + 32'd1 < 32'(n_q)) begin
                        k_d     = k_q + LW'(1);
                        state_d = StCopy;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    j_d = j_q + RW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cal_d    = 1'b0;
        copy_d   = 1'b0;
        stream_d = 1'b0;
        cur_d    = '0;
        dcdw_d   = '0;
        case (state_d)
            StStream: begin
                busy_d   = 1'b1;
                stream_d = 1'b1;
                cur_d    = 33'(l_d);
            end
            StCal: begin
                busy_d = 1'b1;
                cal_d  = (l_d != '0);
                cur_d  = 33'(l_d);
            end
            StCopy: begin
                busy_d = 1'b1;
                copy_d = 1'b1;
                cur_d  = 33'(k_d);
            end
            StRead: begin
                busy_d = 1'b1;
                cur_d  = 33'(k_d);
                dcdw_d = 33'(j_d);
            end
            StDone:  done_d = 1'b1;
            default: ;
        endcase
        bs_d = stream_d ? mem_start[l_d][r_d]  : '0;
        ba_d = stream_d ? mem_to_all[l_d][r_d] : '0;
        bd_d = stream_d ? mem_dense[l_d][r_d]  : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            l_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            j_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cal_q   <= 1'b0;
            copy_q  <= 1'b0;
            cur_q   <= '0;
            dcdw_q  <= '0;
            bs_q    <= '0;
            ba_q    <= '0;
            bd_q    <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            k_q     <= k_d;
            r_q     <= r_d;
            j_q     <= j_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cal_q   <= cal_d;
            copy_q  <= copy_d;
            cur_q   <= cur_d;
            dcdw_q  <= dcdw_d;
            bs_q    <= bs_d;
            ba_q    <= ba_d;
            bd_q    <= bd_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign cal_dy_dy_old       = cal_q;
    assign copy                = copy_q;
    assign stack_reset         = copy_q;
    assign current_layer_index = cur_q;
    assign dc_dw_layer_index   = dcdw_q;
    assign backprop_start      = bs_q;
    assign backprop_to_all     = ba_q;
    assign backprop_dense      = bd_q;

endmodule

// File: tb/tb_backprop_stream_tx.sv
// Directed bench for backprop_stream_tx: per-cycle trace capture with hand-computed expectations.
module tb_backprop_stream_tx;

    localparam int MAXC = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_sel = 2'd0;
    logic [7:0]  wr_layer = 8'd0;
    logic [7:0]  wr_row = 8'd0;
    logic [11:0] wr_data = 12'd0;
    logic        start = 1'b0;
    logic [7:0]  num_layers = 8'd0;
    logic        busy, done, copy, cal_dy_dy_old, stack_reset;
    logic [11:0] backprop_start, backprop_to_all, backprop_dense;
    logic [32:0] current_layer_index, dc_dw_layer_index;

    int checks = 0;
    int errors = 0;

    logic [11:0] tr_bs [0:MAXC];
    logic [11:0] tr_ba [0:MAXC];
    logic [11:0] tr_bd [0:MAXC];
    logic [32:0] tr_cur [0:MAXC];
    logic [32:0] tr_dc [0:MAXC];
    logic        tr_cal [0:MAXC];
    logic        tr_copy [0:MAXC];
    logic        tr_sr [0:MAXC];
    int busy_cnt, done_cnt, done_cyc, copy_cnt;

    backprop_stream_tx #(.DATA_SIZE(4), .SIZE(3), .MAX_LAYER_SIZE(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_layer(wr_layer),
        .wr_row(wr_row), .wr_data(wr_data), .start(start), .num_layers(num_layers),
        .busy(busy), .done(done), .backprop_start(backprop_start),
        .backprop_to_all(backprop_to_all), .backprop_dense(backprop_dense),
        .current_layer_index(current_layer_index), .dc_dw_layer_index(dc_dw_layer_index),
        .copy(copy), .cal_dy_dy_old(cal_dy_dy_old), .stack_reset(stack_reset)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] sel, input logic [7:0] layer, input logic [7:0] row,
                      input logic [11:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_layer = layer; wr_row = row; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Cycle c of the trace is the c-th cycle after the edge that accepts start.
    task automatic run_seq(input logic [7:0] n, input int restart_at, input bit busy_wr);
        @(negedge clk);
        num_layers = n;
        start = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_cyc = 0; copy_cnt = 0;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            tr_bs[c] = backprop_start; tr_ba[c] = backprop_to_all; tr_bd[c] = backprop_dense;
            tr_cur[c] = current_layer_index; tr_dc[c] = dc_dw_layer_index;
            tr_cal[c] = cal_dy_dy_old; tr_copy[c] = copy; tr_sr[c] = stack_reset;
            if (busy) busy_cnt++;
            if (copy) copy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            start = (c == restart_at);
            if (busy_wr) begin
                wr_en = (c == 2); wr_sel = 2'd0; wr_layer = 8'd0; wr_row = 8'd0;
                wr_data = 12'hFFF;
            end
        end
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, copy, cal_dy_dy_old, stack_reset} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {busy, done, copy, cal_dy_dy_old, stack_reset});
        end
        checks++;
        if ({backprop_start, backprop_to_all, backprop_dense, current_layer_index,
             dc_dw_layer_index} !== 102'b0) begin
            errors++;
            $display("FAIL reset_data: buses/indices not zero after reset");
        end
        reset = 1'b0;
        // Abort a running N=2 sequence mid-STREAM.
        @(negedge clk);
        num_layers = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prebusy: got %b expected 1", busy);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, backprop_start, backprop_to_all, backprop_dense,
             current_layer_index, dc_dw_layer_index} !== 104'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b cur=%0h expected all zero",
                     busy, done, current_layer_index);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_nodone: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_single_layer;
        logic [11:0] es [3];
        logic [11:0] ea [3];
        logic [11:0] ed [3];
        es = '{12'h123, 12'h000, 12'h000};
        ea = '{12'h000, 12'h456, 12'h000};
        ed = '{12'h000, 12'h000, 12'h789};
        for (int r = 0; r < 3; r++) begin
            wr(2'd0, 8'd0, 8'(r), es[r]);
            wr(2'd1, 8'd0, 8'(r), ea[r]);
            wr(2'd2, 8'd0, 8'(r), ed[r]);
        end
        run_seq(8'd1, 0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({tr_bs[c], tr_ba[c], tr_bd[c]} !== {es[c-1], ea[c-1], ed[c-1]}) begin
                errors++;
                $display("FAIL single_row%0d: got %h/%h/%h expected %h/%h/%h", c,
                         tr_bs[c], tr_ba[c], tr_bd[c], es[c-1], ea[c-1], ed[c-1]);
            end
        end
        checks++;
        if ({tr_cal[4], tr_bs[4], tr_ba[4], tr_bd[4]} !== 37'b0) begin
            errors++;
            $display("FAIL single_cal: cal=%b bus=%h expected 0 and 0", tr_cal[4], tr_bs[4]);
        end
        checks++;
        if (busy_cnt !== 8 || done_cyc !== 9) begin
            errors++;
            $display("FAIL single_timing: busy=%0d done@%0d expected 8 and 9", busy_cnt, done_cyc);
        end
    endtask

    task automatic test_full_timing;
        int rd_c [6];
        int rd_j [6];
        rd_c = '{10, 11, 12, 14, 15, 16};
        rd_j = '{0, 1, 2, 0, 1, 2};
        wr(2'd0, 8'd1, 8'd0, 12'h9A5);
        run_seq(8'd2, 0, 1'b0);
        checks++;
        if (busy_cnt !== 16 || done_cyc !== 17 || done_cnt !== 1) begin
            errors++;
            $display("FAIL full_timing: busy=%0d done@%0d x%0d expected 16, 17, 1",
                     busy_cnt, done_cyc, done_cnt);
        end
        checks++;
        if (tr_bs[5] !== 12'h9A5 || tr_cur[5] !== 33'd1) begin
            errors++;
            $display("FAIL full_layer1: bus=%h cur=%0d expected 9a5 and 1", tr_bs[5], tr_cur[5]);
        end
        checks++;
        if ({tr_cal[4], tr_cal[8]} !== 2'b01) begin
            errors++;
            $display("FAIL full_cal: got %b expected 01", {tr_cal[4], tr_cal[8]});
        end
        checks++;
        if ({tr_copy[9], tr_sr[9], tr_copy[13], tr_sr[13]} !== 4'b1111 || copy_cnt !== 2) begin
            errors++;
            $display("FAIL full_copy: got %b count %0d expected 1111 count 2",
                     {tr_copy[9], tr_sr[9], tr_copy[13], tr_sr[13]}, copy_cnt);
        end
        checks++;
        if (tr_cur[9] !== 33'd0 || tr_cur[13] !== 33'd1) begin
            errors++;
            $display("FAIL full_copy_idx: got %0d,%0d expected 0,1", tr_cur[9], tr_cur[13]);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tr_dc[rd_c[i]] !== 33'(rd_j[i])) begin
                errors++;
                $display("FAIL full_dcdw_c%0d: got %0d expected %0d", rd_c[i], tr_dc[rd_c[i]],
                         rd_j[i]);
            end
        end
        checks++;
        if (tr_dc[9] !== 33'd0 || tr_dc[17] !== 33'd0 || tr_bs[9] !== 12'h0) begin
            errors++;
            $display("FAIL full_idle_zero: dc9=%0d dc17=%0d bs9=%h expected 0", tr_dc[9],
                     tr_dc[17], tr_bs[9]);
        end
    endtask

    task automatic test_boundaries;
        run_seq(8'd0, 0, 1'b0);
        checks++;
        if (busy_cnt !== 0 || done_cyc !== 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL n0: busy=%0d done@%0d x%0d expected 0, 1, 1", busy_cnt, done_cyc,
                     done_cnt);
        end
        run_seq(8'd9, 0, 1'b0);
        checks++;
        if (busy_cnt !== 32 || done_cyc !== 33) begin
            errors++;
            $display("FAIL n9_clamp: busy=%0d done@%0d expected 32 and 33", busy_cnt, done_cyc);
        end
        checks++;
        if (tr_copy[29] !== 1'b1 || tr_cur[29] !== 33'd3 || copy_cnt !== 4) begin
            errors++;
            $display("FAIL n9_last_copy: copy=%b cur=%0d count=%0d expected 1, 3, 4",
                     tr_copy[29], tr_cur[29], copy_cnt);
        end
    endtask

    task automatic test_illegal;
        run_seq(8'd2, 5, 1'b1);
        checks++;
        if (busy_cnt !== 16 || done_cnt !== 1 || done_cyc !== 17) begin
            errors++;
            $display("FAIL start_while_busy: busy=%0d done x%0d @%0d expected 16, 1, 17",
                     busy_cnt, done_cnt, done_cyc);
        end
        wr(2'd0, 8'd4, 8'd0, 12'hAAA);
        wr(2'd0, 8'd0, 8'd3, 12'hCCC);
        wr(2'd3, 8'd0, 8'd2, 12'hBBB);
        wr(2'd1, 8'd64, 8'd1, 12'hDDD);
        run_seq(8'd1, 0, 1'b0);
        checks++;
        if ({tr_bs[1], tr_ba[1], tr_bd[1]} !== 36'h123_000_000) begin
            errors++;
            $display("FAIL illegal_row0: got %h/%h/%h expected 123/000/000",
                     tr_bs[1], tr_ba[1], tr_bd[1]);
        end
        checks++;
        if ({tr_bs[2], tr_ba[2], tr_bd[2]} !== 36'h000_456_000) begin
            errors++;
            $display("FAIL illegal_row1: got %h/%h/%h expected 000/456/000",
                     tr_bs[2], tr_ba[2], tr_bd[2]);
        end
        checks++;
        if ({tr_bs[3], tr_ba[3], tr_bd[3]} !== 36'h000_000_789) begin
            errors++;
            $display("FAIL illegal_row2: got %h/%h/%h expected 000/000/789",
                     tr_bs[3], tr_ba[3], tr_bd[3]);
        end
    endtask

    task automatic test_back_to_back;
        run_seq(8'd1, 9, 1'b0);
        checks++;
        if (busy_cnt !== 8 || done_cnt !== 1) begin
            errors++;
            $display("FAIL b2b_done_start: busy=%0d done x%0d expected 8 and 1", busy_cnt,
                     done_cnt);
        end
        run_seq(8'd1, 10, 1'b0);
        checks++;
        if (busy_cnt !== 16 || done_cnt !== 2 || done_cyc !== 9) begin
            errors++;
            $display("FAIL b2b_idle_start: busy=%0d done x%0d @%0d expected 16, 2, 9",
                     busy_cnt, done_cnt, done_cyc);
        end
        checks++;
        if (tr_bs[11] !== 12'h123 || tr_cur[11] !== 33'd0 || tr_bd[13] !== 12'h789) begin
            errors++;
            $display("FAIL b2b_layer0: bs=%h cur=%0d bd=%h expected 123, 0, 789",
                     tr_bs[11], tr_cur[11], tr_bd[13]);
        end
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_full_timing();
        test_boundaries();
        test_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
